// File: rtl/ir_pi_steer.sv
// rtl/ir_pi_steer.sv - IR sensor-pair sequencer with decimated PI steering loop
// Scans NPAIRS left/right IR pairs through the A2D, then computes saturated motor commands.
module ir_pi_steer #(
   parameter int          NPAIRS     = 3,
   parameter int          SETTLE_CYC = 4095,
   parameter int          GAP_CYC    = 32,
   parameter int          INT_DEC    = 4,
   parameter logic [14:0] PTERM      = 15'h3680,
   parameter logic [11:0] ITERM      = 12'h500,
   parameter logic [11:0] FWD_MAX    = 12'h700
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                go,
   input  logic                clr_intgrl,
   input  logic [11:0]         A2D_res,
   input  logic                cnv_cmplt,
   output logic                strt_cnv,
   output logic [2:0]          chnnl,
   output logic [NPAIRS-1:0]   IR_en,
   output logic signed [10:0]  lft_reg,
   output logic signed [10:0]  rht_reg,
   output logic                out_vld
);

   localparam int TMAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
   localparam int TW   = $clog2(TMAX);
   localparam int KW   = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
   localparam int DW   = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;

   localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
   localparam logic [KW-1:0] K_LAST   = KW'(NPAIRS - 1);
   localparam logic [DW-1:0] D_LAST   = DW'(INT_DEC - 1);

   typedef enum logic [3:0] {
      IDLE, SETTLE, CNV_R, GAP, CNV_L, ACC_L, ERR, INTG, ICOMP, PCOMP, RHT, LFT
   } state_t;

   state_t                state_q;
   logic [TW-1:0]         timer_q;
   logic [KW-1:0]         k_q;
   logic [DW-1:0]         dec_q;
   logic signed [16:0]    accum_q;
   logic signed [11:0]    err_q;
   logic signed [11:0]    intg_q;
   logic [11:0]           fwd_q;
   logic signed [17:0]    icomp_q;
   logic signed [17:0]    pcomp_q;
   logic                  strt_q;
   logic [2:0]            chnnl_q;
   logic [NPAIRS-1:0]     ir_en_q;
   logic signed [10:0]    lft_q;
   logic signed [10:0]    rht_q;
   logic                  vld_q;

   function automatic logic signed [11:0] sat12(input logic signed [16:0] v);
      if (v > 17'sd2047)
         return 12'h7FF;
      else if (v < -17'sd2048)
         return 12'h800;
      else
         return 12'(v);
   endfunction

   function automatic logic signed [10:0] sat11(input logic signed [17:0] v);
      if (v > 18'sd1023)
         return 11'h3FF;
      else if (v < -18'sd1024)
         return 11'h400;
      else
         return 11'(v);
   endfunction

   // Pair k carries weight 2^k: right pulls the error positive, left negative.
   logic [16:0]        a2d_sh;
   logic signed [16:0] accum_add_d, accum_sub_d;
   logic signed [11:0] err_d, intg_d;
   logic signed [16:0] intg_sum;
   logic signed [27:0] err_x, pterm_x, p_prod, p_shr;
   logic signed [27:0] intg_x, iterm_x, i_prod, i_shr;
   logic signed [17:0] fwd_x, rht_sum, lft_sum;
   logic signed [10:0] rht_d, lft_d;
   logic [DW-1:0]      dec_d;

   assign a2d_sh      = {5'b0, A2D_res} << k_q;
   assign accum_add_d = accum_q + $signed(a2d_sh);
   assign accum_sub_d = accum_q - $signed(a2d_sh);
   assign err_d       = sat12(accum_q);
   assign intg_sum    = {{5{intg_q[11]}}, intg_q} + {{9{err_q[11]}}, err_q[11:4]};
   assign intg_d      = sat12(intg_sum);

   assign err_x   = {{16{err_q[11]}}, err_q};
   assign pterm_x = {13'b0, PTERM};
   assign p_prod  = err_x * pterm_x;
   assign p_shr   = p_prod >>> 13;
   assign intg_x  = {{16{intg_q[11]}}, intg_q};
   assign iterm_x = {16'b0, ITERM};
   assign i_prod  = intg_x * iterm_x;
   assign i_shr   = i_prod >>> 11;

   assign fwd_x   = {6'b0, fwd_q};
   assign rht_sum = fwd_x - pcomp_q - icomp_q;
   assign lft_sum = fwd_x + pcomp_q + icomp_q;
   assign rht_d   = sat11(rht_sum);
   assign lft_d   = sat11(lft_sum);
   assign dec_d   = (dec_q == D_LAST) ? '0 : dec_q + DW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         k_q     <= '0;
         dec_q   <= '0;
         accum_q <= '0;
         err_q   <= '0;
         intg_q  <= '0;
         fwd_q   <= '0;
         icomp_q <= '0;
         pcomp_q <= '0;
         strt_q  <= 1'b0;
         chnnl_q <= '0;
         ir_en_q <= '0;
         lft_q   <= '0;
         rht_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         strt_q <= 1'b0;
         vld_q  <= 1'b0;
         // Dropping go abandons the scan but keeps the integrator and decimator phase.
         if (state_q != IDLE && !go) begin
            state_q <= IDLE;
            ir_en_q <= '0;
            lft_q   <= '0;
            rht_q   <= '0;
            fwd_q   <= '0;
         end else begin
            case (state_q)
               IDLE: if (go) begin
                  accum_q <= '0;
                  k_q     <= '0;
                  ir_en_q <= NPAIRS'(1);
                  chnnl_q <= 3'd0;
                  timer_q <= '0;
                  state_q <= SETTLE;
               end
               SETTLE: begin
                  timer_q <= timer_q + TW'(1);
                  if (timer_q == SET_LAST) begin
                     strt_q  <= 1'b1;
                     state_q <= CNV_R;
                  end
               end
               CNV_R: if (cnv_cmplt) begin
                  accum_q <= accum_add_d;
                  timer_q <= '0;
                  state_q <= GAP;
               end
               GAP: begin
                  timer_q <= timer_q + TW'(1);
                  if (timer_q == GAP_LAST) begin
                     strt_q  <= 1'b1;
                     chnnl_q <= chnnl_q | 3'd1;
                     state_q <= CNV_L;
                  end
               end
               CNV_L: if (cnv_cmplt) begin
                  accum_q <= accum_sub_d;
                  if (k_q == K_LAST) begin
                     ir_en_q <= '0;
                     state_q <= ERR;
                  end else begin
                     k_q     <= k_q + KW'(1);
                     ir_en_q <= NPAIRS'(1) << (k_q + KW'(1));
                     chnnl_q <= 3'(k_q + KW'(1)) << 1;
                     timer_q <= '0;
                     state_q <= SETTLE;
                  end
               end
               ERR: begin
                  err_q   <= err_d;
                  dec_q   <= dec_d;
                  state_q <= INTG;
               end
               INTG: begin
                  if (clr_intgrl)
                     intg_q <= '0;
                  else if (dec_q == '0)
                     intg_q <= intg_d;
                  if (dec_q == '0 && fwd_q < FWD_MAX)
                     fwd_q <= fwd_q + 12'd1;
                  state_q <= ICOMP;
               end
               ICOMP: begin
                  icomp_q <= 18'(i_shr);
                  state_q <= PCOMP;
               end
               PCOMP: begin
                  pcomp_q <= 18'(p_shr);
                  state_q <= RHT;
               end
               RHT: begin
                  rht_q   <= rht_d;
                  state_q <= LFT;
               end
               LFT: begin
                  lft_q   <= lft_d;
                  vld_q   <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign strt_cnv = strt_q;
   assign chnnl    = chnnl_q;
   assign IR_en    = ir_en_q;
   assign lft_reg  = lft_q;
   assign rht_reg  = rht_q;
   assign out_vld  = vld_q;

endmodule
